// File: rtl/npu_pkg.sv
// Shared NPU definitions for the sram_B read path: widths, address type and read-engine states.
package npu_pkg;

    localparam int SRAM_B_ADDR_W = 10;
    localparam int SRAM_B_DATA_W = 8;

    typedef logic [SRAM_B_ADDR_W-1:0] sram_b_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_t;

endpackage

// File: rtl/npu_skid_fifo.sv
// Two-entry synchronous FIFO used as the skid buffer behind the one-cycle sram_B read.
module npu_skid_fifo #(
    parameter int W = 9
) (
    input  logic         rpll_clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge rpll_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sram_b_reader.sv
// Streams a contiguous (or strided, with SRAM_B_RD_STRIDE_EN) run of sram_B bytes onto a
// valid/ready interface; a 2-entry skid FIFO absorbs the in-flight read under backpressure.
module sram_b_reader
    import npu_pkg::*;
#(
    parameter int ADDR_W     = SRAM_B_ADDR_W,
    parameter int DATA_W     = SRAM_B_DATA_W,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              rpll_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef SRAM_B_RD_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_B_addr,
    input  logic [DATA_W-1:0] sram_B_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    rd_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W-1:0] step;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   head;
    logic [2:0]        occ;
    logic              pop;
    logic              issue;
    logic              accept;

`ifdef SRAM_B_RD_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;
    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    assign pop    = out_valid & out_ready;
    // Occupancy after this cycle's pop; a new read may only go out if its byte is guaranteed a slot.
    assign occ    = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue  = (state == FETCH) && (occ < 3'(FIFO_DEPTH));
    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len == '0) ? FIN : FETCH;
            FETCH: if (issue && remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN: if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                       state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rpll_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            addr_hold     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
`ifdef SRAM_B_RD_STRIDE_EN
            stride_q      <= '0;
`endif
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue && (remaining == LEN_W'(1));
            if (accept && len != '0) begin
                ptr       <= base_addr;
                remaining <= len;
`ifdef SRAM_B_RD_STRIDE_EN
                stride_q  <= stride;
`endif
            end else if (issue) begin
                ptr       <= ptr + step;
                remaining <= remaining - LEN_W'(1);
                addr_hold <= ptr;
            end
        end
    end

    // The address goes out combinationally in the issue cycle so the first byte lands two cycles after start.
    assign sram_B_addr = issue ? ptr : addr_hold;

    npu_skid_fifo #(.W(DATA_W + 1)) u_fifo (
        .rpll_clk  (rpll_clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, sram_B_dout}),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (head)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head[DATA_W-1:0];
    assign out_last  = head[DATA_W] & out_valid;
    assign busy      = (state == FETCH) || (state == DRAIN);
    assign done      = (state == FIN);

endmodule

// File: tb/tb_sram_b_reader.sv
// Directed bench for sram_b_reader: table of stream commands plus reset and stride sequences.
module tb_sram_b_reader;

    logic       rpll_clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] base_addr;
    logic [10:0] len;
    logic [9:0] stride;
    logic       busy, done;
    logic [9:0] sram_B_addr;
    logic [7:0] sram_B_dout;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;

    logic [7:0] mem [1024];

    int errors = 0;
    int checks = 0;

    always #5 rpll_clk = ~rpll_clk;

    always_ff @(posedge rpll_clk) sram_B_dout <= mem[sram_B_addr];

    sram_b_reader dut (
        .rpll_clk    (rpll_clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
`ifdef SRAM_B_RD_STRIDE_EN
        .stride      (stride),
`endif
        .busy        (busy),
        .done        (done),
        .sram_B_addr (sram_B_addr),
        .sram_B_dout (sram_B_dout),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    typedef struct packed {
        logic [9:0]  base;
        logic [10:0] len;
        logic [9:0]  stride;
        logic        tog;
        logic        dbl;
        logic [63:0] data;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " out_last"}, int'(out_last), 0);
        chk({tag, " out_data"}, int'(out_data), 0);
        chk({tag, " sram_B_addr"}, int'(sram_B_addr), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] got_d[$];
        logic       got_l[$];
        int         addr_log[$];
        int         last_addr = -1;
        int         first_valid = -1;
        int         done_cnt = 0;
        int         done_idx = -1;
        int         last_acc = -1;
        int         stab_err = 0;
        logic       busy_seen = 1'b0;
        logic       pend = 1'b0;
        logic [7:0] pend_data = '0;
        logic [9:0] a;

        for (int k = 0; k < int'(v.len); k++) begin
            a = v.base + 10'(k) * v.stride;
            mem[a] = v.data[8*(7-k) +: 8];
        end

        @(posedge rpll_clk); #1;
        start = 1'b1; base_addr = v.base; len = v.len; stride = v.stride; out_ready = 1'b1;
        @(posedge rpll_clk); #1;
        for (int idx = 0; idx < 100; idx++) begin
            out_ready = v.tog ? (idx % 3 == 0) : 1'b1;
            if (v.dbl && idx == 3) begin
                start = 1'b1; base_addr = 10'd0; len = 11'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (out_valid && first_valid < 0) first_valid = idx;
            if (busy) busy_seen = 1'b1;
            if (busy && int'(sram_B_addr) != last_addr) begin
                addr_log.push_back(int'(sram_B_addr));
                last_addr = int'(sram_B_addr);
            end
            if (pend && !(out_valid && out_data == pend_data)) stab_err++;
            pend      = out_valid && !out_ready;
            pend_data = out_data;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                last_acc = idx;
            end
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            if (done_idx >= 0 && idx >= done_idx + 3) break;
            @(posedge rpll_clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;

        chk({tag, " byte count"}, got_d.size(), int'(v.len));
        chk({tag, " done count"}, done_cnt, 1);
        if (v.len == 0) begin
            chk({tag, " busy never"}, int'(busy_seen), 0);
            chk({tag, " no valid"}, first_valid, -1);
            chk({tag, " done idx"}, done_idx, 0);
        end else begin
            chk({tag, " busy seen"}, int'(busy_seen), 1);
            chk({tag, " first valid latency"}, first_valid, 2);
            chk({tag, " done after last"}, done_idx, last_acc + 1);
            chk({tag, " stable while stalled"}, stab_err, 0);
            chk({tag, " addr count"}, addr_log.size(), int'(v.len));
            for (int k = 0; k < int'(v.len) && k < got_d.size(); k++) begin
                chk($sformatf("%s data[%0d]", tag, k), int'(got_d[k]), int'(v.data[8*(7-k) +: 8]));
                chk($sformatf("%s last[%0d]", tag, k), int'(got_l[k]), (k == int'(v.len) - 1) ? 1 : 0);
            end
            for (int k = 0; k < int'(v.len) && k < addr_log.size(); k++) begin
                a = v.base + 10'(k) * v.stride;
                chk($sformatf("%s addr[%0d]", tag, k), addr_log[k], int'(a));
            end
        end
    endtask

    vec_t tbl [6];
    int   dn;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; stride = 10'd1; out_ready = 1'b1;

        //          base      len     stride  tog   dbl   data (first byte in MSB)
        tbl[0] = '{10'd0,    11'd4,  10'd1,  1'b0, 1'b0, 64'hAABBCCDD_00000000};
        tbl[1] = '{10'd0,    11'd4,  10'd1,  1'b1, 1'b0, 64'hAABBCCDD_00000000};
        tbl[2] = '{10'd1022, 11'd4,  10'd1,  1'b0, 1'b0, 64'h11223344_00000000};
        tbl[3] = '{10'd100,  11'd8,  10'd1,  1'b1, 1'b0, 64'h3C4D5E6F_708192A3};
        tbl[4] = '{10'd500,  11'd1,  10'd1,  1'b0, 1'b0, 64'h7E000000_00000000};
        tbl[5] = '{10'd200,  11'd8,  10'd1,  1'b0, 1'b1, 64'hE1E2E3E4_E5E6E7E8};

        repeat (3) @(posedge rpll_clk);
        #2;
        chk_idle_zero("reset");
        @(posedge rpll_clk); #3;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        run_vec('{10'd0, 11'd0, 10'd1, 1'b0, 1'b0, 64'h0}, "len0");

        // Reset asserted between clock edges mid-stream must clear outputs at once and suppress done.
        for (int k = 0; k < 8; k++) mem[300 + k] = 8'hC0 + 8'(k);
        @(posedge rpll_clk); #1;
        start = 1'b1; base_addr = 10'd300; len = 11'd8; out_ready = 1'b1;
        @(posedge rpll_clk); #1;
        start = 1'b0;
        repeat (4) @(posedge rpll_clk);
        #3;
        chk("pre-reset streaming", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk_idle_zero("async reset");
        dn = 0;
        repeat (2) begin
            @(posedge rpll_clk); #1;
            if (done) dn++;
        end
        #2 rst = 1'b0;
        repeat (6) begin
            @(posedge rpll_clk); #1;
            if (done) dn++;
        end
        chk("no done after reset", dn, 0);
        run_vec('{10'd40, 11'd3, 10'd1, 1'b0, 1'b0, 64'h5A6B7C00_00000000}, "post-reset");

`ifdef SRAM_B_RD_STRIDE_EN
        run_vec('{10'd0, 11'd3, 10'd32, 1'b0, 1'b0, 64'h9192930000000000}, "stride32");
        run_vec('{10'd1000, 11'd3, 10'd16, 1'b1, 1'b0, 64'hA1A2A30000000000}, "stride wrap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
